// File: rtl/gcd_datapath.sv
// Operand datapath for the subtract-and-compare GCD engine: A/B working registers,
// compare flags for the controller, iteration counter and a handshaked result register.
module gcd_datapath #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             a_sel,
  input  logic             b_sel,
  input  logic             a_ld,
  input  logic             b_ld,
  input  logic             op_en,
  output logic             a_lt_b,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic [WIDTH-1:0] gcd_out,
  output logic [CNT_W-1:0] iter_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             ovf
);

  logic [WIDTH-1:0] a_q, b_q;
  logic [WIDTH-1:0] a_diff, b_diff;
  logic [WIDTH-1:0] a_nxt, b_nxt;
  logic [WIDTH-1:0] res;
  logic [CNT_W-1:0] cnt_q;
  logic             zero_op;
  logic             new_load;
  logic             sub_step;
  logic             cnt_sat;

  assign a_diff = a_q - b_q;
  assign b_diff = b_q - a_q;
  assign a_nxt  = a_sel ? a_diff : a_in;
  assign b_nxt  = b_sel ? b_diff : b_in;

  // A zero operand ends the computation: GCD(x,0) = x.
  assign zero_op = (a_q == '0) || (b_q == '0);
  assign res     = (a_q == '0) ? b_q : a_q;

  always_comb begin
    a_lt_b = 1'b0;
    a_gt_b = 1'b0;
    a_eq_b = 1'b0;
    if (zero_op || (a_q == b_q)) begin
      a_eq_b = 1'b1;
    end else if (a_q < b_q) begin
      a_lt_b = 1'b1;
    end else begin
      a_gt_b = 1'b1;
    end
  end

  assign new_load = (a_ld & ~a_sel) | (b_ld & ~b_sel);
  assign sub_step = (a_ld & a_sel) | (b_ld & b_sel);
  assign cnt_sat  = (cnt_q == {CNT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
    end else begin
      if (a_ld) a_q <= a_nxt;
      if (b_ld) b_q <= b_nxt;
      if (new_load) begin
        cnt_q <= '0;
      end else if (sub_step && !cnt_sat) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  // A capture while a result is pending and not being taken loses that result.
  always_ff @(posedge clk) begin
    if (rst) begin
      gcd_out   <= '0;
      iter_out  <= '0;
      out_valid <= 1'b0;
      ovf       <= 1'b0;
    end else if (op_en) begin
      gcd_out   <= res;
      iter_out  <= cnt_q;
      out_valid <= 1'b1;
      if (out_valid && !out_ready) ovf <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_gcd_datapath.sv
// Directed bench for gcd_datapath: a default-width instance plus a CNT_W=4 instance
// sharing the same stimulus, the latter used for counter saturation.
module tb_gcd_datapath;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] a_in, b_in;
  logic       a_sel, b_sel, a_ld, b_ld, op_en, out_ready;

  logic       lt8, gt8, eq8, valid8, ovf8;
  logic [7:0] gcd8, iter8;
  logic       lt4, gt4, eq4, valid4, ovf4;
  logic [7:0] gcd4;
  logic [3:0] iter4;

  int total = 0;
  int bad = 0;

  localparam logic [2:0] F_LT = 3'b100, F_GT = 3'b010, F_EQ = 3'b001;

  always #5 clk = ~clk;

  gcd_datapath #(.WIDTH(8), .CNT_W(8)) u8 (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .a_sel(a_sel), .b_sel(b_sel),
    .a_ld(a_ld), .b_ld(b_ld), .op_en(op_en), .a_lt_b(lt8), .a_gt_b(gt8), .a_eq_b(eq8),
    .gcd_out(gcd8), .iter_out(iter8), .out_valid(valid8), .out_ready(out_ready), .ovf(ovf8)
  );

  gcd_datapath #(.WIDTH(8), .CNT_W(4)) u4 (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .a_sel(a_sel), .b_sel(b_sel),
    .a_ld(a_ld), .b_ld(b_ld), .op_en(op_en), .a_lt_b(lt4), .a_gt_b(gt4), .a_eq_b(eq4),
    .gcd_out(gcd4), .iter_out(iter4), .out_valid(valid4), .out_ready(out_ready), .ovf(ovf4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] a, input logic [7:0] b);
    a_in = a; b_in = b; a_sel = 0; b_sel = 0; a_ld = 1; b_ld = 1;
    tick();
    a_ld = 0; b_ld = 0;
  endtask

  task automatic capture(input logic rdy);
    op_en = 1; out_ready = rdy;
    tick();
    op_en = 0; out_ready = 0;
  endtask

  // Controller loop driven by the u8 flags; returns number of subtraction steps.
  task automatic run_to_eq(input int max_steps, output int steps, output bit timed_out);
    steps = 0;
    timed_out = 1'b0;
    while (!eq8) begin
      if (steps >= max_steps) begin
        timed_out = 1'b1;
        break;
      end
      a_sel = 1; b_sel = 1;
      a_ld = gt8; b_ld = lt8;
      tick();
      a_ld = 0; b_ld = 0;
      steps++;
    end
  endtask

  task automatic test_reset();
    rst = 1;
    tick(); tick();
    rst = 0;
    total++;
    if ({lt8, gt8, eq8, gcd8, iter8, valid8, ovf8} !== {F_EQ, 8'd0, 8'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset8: got flags=%b gcd=%0d iter=%0d v=%b ovf=%b, want 001 0 0 0 0",
               {lt8, gt8, eq8}, gcd8, iter8, valid8, ovf8);
    end
    total++;
    if ({lt4, gt4, eq4, gcd4, iter4, valid4, ovf4} !== {F_EQ, 8'd0, 4'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset4: got flags=%b gcd=%0d iter=%0d v=%b ovf=%b, want 001 0 0 0 0",
               {lt4, gt4, eq4}, gcd4, iter4, valid4, ovf4);
    end
  endtask

  task automatic test_basic();
    logic [2:0] exp_f [5];
    exp_f = '{F_GT, F_GT, F_LT, F_GT, F_EQ};
    load(8'd48, 8'd18);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({lt8, gt8, eq8} !== exp_f[i]) begin
        bad++;
        $display("FAIL basic_flags[%0d]: got %b want %b", i, {lt8, gt8, eq8}, exp_f[i]);
      end
      if (eq8) break;
      a_sel = 1; b_sel = 1; a_ld = gt8; b_ld = lt8;
      tick();
      a_ld = 0; b_ld = 0;
    end
    capture(1'b0);
    total++;
    if ({gcd8, iter8, valid8, ovf8} !== {8'd6, 8'd4, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL basic_result: got gcd=%0d iter=%0d v=%b ovf=%b want 6 4 1 0",
               gcd8, iter8, valid8, ovf8);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    total++;
    if (valid8 !== 1'b0) begin
      bad++;
      $display("FAIL basic_accept: got valid=%b want 0", valid8);
    end
  endtask

  task automatic test_zero_and_hold();
    load(8'd0, 8'd25);
    total++;
    if ({lt8, gt8, eq8} !== F_EQ) begin
      bad++;
      $display("FAIL zero_flags: got %b want 001", {lt8, gt8, eq8});
    end
    capture(1'b0);
    total++;
    if ({gcd8, iter8, valid8} !== {8'd25, 8'd0, 1'b1}) begin
      bad++;
      $display("FAIL zero_result: got gcd=%0d iter=%0d v=%b want 25 0 1", gcd8, iter8, valid8);
    end
    // Hold with no acceptance while the operands change underneath.
    load(8'd9, 8'd3);
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({gcd8, iter8, valid8} !== {8'd25, 8'd0, 1'b1}) begin
        bad++;
        $display("FAIL hold[%0d]: got gcd=%0d iter=%0d v=%b want 25 0 1", i, gcd8, iter8, valid8);
      end
      if (i < 4) tick();
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    total++;
    if ({valid8, ovf8} !== 2'b00) begin
      bad++;
      $display("FAIL hold_accept: got valid=%b ovf=%b want 0 0", valid8, ovf8);
    end
    load(8'd0, 8'd0);
    capture(1'b0);
    total++;
    if ({gcd8, valid8, eq8} !== {8'd0, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL zero_zero: got gcd=%0d v=%b eq=%b want 0 1 1", gcd8, valid8, eq8);
    end
  endtask

  task automatic test_back_to_back();
    // A zero/zero result is pending; capture a new one in the same cycle it is accepted.
    load(8'd0, 8'd9);
    capture(1'b1);
    total++;
    if ({gcd8, valid8, ovf8} !== {8'd9, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL b2b_capture: got gcd=%0d v=%b ovf=%b want 9 1 0", gcd8, valid8, ovf8);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    total++;
    if (valid8 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_accept: got valid=%b want 0", valid8);
    end
  endtask

  task automatic test_overflow();
    int steps;
    bit to;
    load(8'd48, 8'd18);
    run_to_eq(20, steps, to);
    capture(1'b0);
    total++;
    if (to || {gcd8, valid8, ovf8} !== {8'd6, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL ovf_first: got gcd=%0d v=%b ovf=%b timeout=%b want 6 1 0 0", gcd8, valid8, ovf8, to);
    end
    load(8'd35, 8'd14);
    run_to_eq(20, steps, to);
    capture(1'b0);
    total++;
    if (to || {gcd8, iter8, valid8, ovf8} !== {8'd7, 8'd3, 1'b1, 1'b1}) begin
      bad++;
      $display("FAIL ovf_second: got gcd=%0d iter=%0d v=%b ovf=%b timeout=%b want 7 3 1 1 0",
               gcd8, iter8, valid8, ovf8, to);
    end
    out_ready = 1;
    tick();
    out_ready = 0;
    tick();
    total++;
    if ({valid8, ovf8} !== 2'b01) begin
      bad++;
      $display("FAIL ovf_sticky: got valid=%b ovf=%b want 0 1", valid8, ovf8);
    end
  endtask

  task automatic test_rst_mid();
    load(8'd48, 8'd18);
    for (int i = 0; i < 2; i++) begin
      a_sel = 1; b_sel = 1; a_ld = gt8; b_ld = lt8;
      tick();
      a_ld = 0; b_ld = 0;
    end
    capture(1'b0);
    total++;
    if ({lt8, gcd8, iter8, valid8} !== {1'b1, 8'd12, 8'd2, 1'b1}) begin
      bad++;
      $display("FAIL rst_pre: got lt=%b gcd=%0d iter=%0d v=%b want 1 12 2 1", lt8, gcd8, iter8, valid8);
    end
    rst = 1;
    tick();
    rst = 0;
    total++;
    if ({lt8, gt8, eq8, gcd8, iter8, valid8, ovf8} !== {F_EQ, 8'd0, 8'd0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL rst_mid: got flags=%b gcd=%0d iter=%0d v=%b ovf=%b want 001 0 0 0 0",
               {lt8, gt8, eq8}, gcd8, iter8, valid8, ovf8);
    end
  endtask

  task automatic test_saturate();
    int steps;
    bit to;
    load(8'd255, 8'd1);
    run_to_eq(300, steps, to);
    total++;
    if (to || steps != 254) begin
      bad++;
      $display("FAIL sat_steps: got steps=%0d timeout=%b want 254 0", steps, to);
    end
    capture(1'b0);
    total++;
    if ({gcd4, iter4, gcd8, iter8} !== {8'd1, 4'd15, 8'd1, 8'd254}) begin
      bad++;
      $display("FAIL sat_result: got gcd4=%0d iter4=%0d gcd8=%0d iter8=%0d want 1 15 1 254",
               gcd4, iter4, gcd8, iter8);
    end
  endtask

  initial begin
    rst = 1; a_in = 0; b_in = 0; a_sel = 0; b_sel = 0;
    a_ld = 0; b_ld = 0; op_en = 0; out_ready = 0;
    test_reset();
    test_basic();
    test_zero_and_hold();
    test_back_to_back();
    test_overflow();
    test_rst_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
